// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    OUT   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] PC_INCR          = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_reg.sv
// Fetch program counter: synchronous reset, load has priority over increment.
// Increment wraps naturally modulo 2^32.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        incr,
  output logic [31:0] pc
);

  logic [31:0] pc_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg <= RESET_PC;
    end else if (load) begin
      pc_reg <= load_val;
    end else if (incr) begin
      pc_reg <= pc_reg + PC_INCR;
    end
  end

  assign pc = pc_reg;

endmodule

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch: REQ -> OUT -> REQ, redirect has priority.
// Define FETCH_ALIGN_CHECK_EN to trap misaligned redirects in FAULT instead of masking pc[1:0].
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        misalign
);

  fetch_state_t state_reg, state_next;
  logic        instr_valid_reg, instr_valid_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] instr_pc_reg, instr_pc_next;
  logic [31:0] pc;
  logic        pc_load, pc_incr;
  logic [31:0] pc_load_val;
  logic        redirect_bad;

`ifdef FETCH_ALIGN_CHECK_EN
  assign pc_load_val  = redirect_pc;
  assign redirect_bad = (redirect_pc[1:0] != 2'b00);
`else
  assign pc_load_val  = redirect_pc & ~32'h3;
  assign redirect_bad = 1'b0;
`endif

  fetch_pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk     (clk),
    .rst     (rst),
    .load    (pc_load),
    .load_val(pc_load_val),
    .incr    (pc_incr),
    .pc      (pc)
  );

  always_comb begin
    state_next       = state_reg;
    instr_valid_next = instr_valid_reg;
    instr_next       = instr_reg;
    instr_pc_next    = instr_pc_reg;
    pc_load          = 1'b0;
    pc_incr          = 1'b0;
    case (state_reg)
      REQ: begin
        if (imem_ack) begin
          instr_next       = imem_rdata;
          instr_pc_next    = pc;
          instr_valid_next = 1'b1;
          pc_incr          = 1'b1;
          state_next       = OUT;
        end
      end
      OUT: begin
        if (instr_ready) begin
          instr_valid_next = 1'b0;
          state_next       = REQ;
        end
      end
      default: begin
        instr_valid_next = 1'b0;
      end
    endcase
    // Redirect overrides whatever the state logic decided this cycle.
    if (redirect_valid) begin
      pc_load          = 1'b1;
      pc_incr          = 1'b0;
      instr_next       = instr_reg;
      instr_pc_next    = instr_pc_reg;
      instr_valid_next = 1'b0;
      state_next       = redirect_bad ? FAULT : REQ;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= REQ;
      instr_valid_reg <= 1'b0;
      instr_reg       <= 32'h0;
      instr_pc_reg    <= 32'h0;
    end else begin
      state_reg       <= state_next;
      instr_valid_reg <= instr_valid_next;
      instr_reg       <= instr_next;
      instr_pc_reg    <= instr_pc_next;
    end
  end

  // Request is gated by rst so no read is issued while reset is held.
  assign imem_req    = (state_reg == REQ) && !rst;
  assign imem_addr   = pc;
  assign instr_valid = instr_valid_reg;
  assign instr       = instr_reg;
  assign instr_pc    = instr_pc_reg;

`ifdef FETCH_ALIGN_CHECK_EN
  assign misalign = (state_reg == FAULT) && !rst;
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, hand-written reset sequence,
// then randomized traffic against a behavioural model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        misalign;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready),
    .misalign      (misalign)
  );

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_ipc;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rv, logic [31:0] rpc, logic ack, logic [31:0] rdata,
                              logic ready, logic e_req, logic [31:0] e_addr, logic e_valid,
                              logic [31:0] e_instr, logic [31:0] e_ipc, logic e_mis);
    vec_t v;
    v.rst = 1'b0; v.rv = rv; v.rpc = rpc; v.ack = ack; v.rdata = rdata; v.ready = ready;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_instr = e_instr; v.e_ipc = e_ipc; v.e_mis = e_mis;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs on the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic r, input logic rv, input logic [31:0] rpc, input logic ack,
                       input logic [31:0] rdata, input logic ready);
    @(negedge clk);
    rst = r; redirect_valid = rv; redirect_pc = rpc;
    imem_ack = ack; imem_rdata = rdata; instr_ready = ready;
    #1;
  endtask

  task automatic check_outs(input string tag, input logic e_req, input logic [31:0] e_addr,
                            input logic e_valid, input logic [31:0] e_instr,
                            input logic [31:0] e_ipc, input logic e_mis);
    chk({tag, ".imem_req"}, {31'b0, imem_req}, {31'b0, e_req});
    if (e_req) chk({tag, ".imem_addr"}, imem_addr, e_addr);
    chk({tag, ".instr_valid"}, {31'b0, instr_valid}, {31'b0, e_valid});
    if (e_valid) begin
      chk({tag, ".instr"}, instr, e_instr);
      chk({tag, ".instr_pc"}, instr_pc, e_ipc);
    end
    chk({tag, ".misalign"}, {31'b0, misalign}, {31'b0, e_mis});
  endtask

  // Behavioural model: what the fetch unit is holding and where it fetches next.
  logic [31:0] m_pc, m_instr, m_ipc;
  bit          m_hold, m_fault;

  function automatic void model_step(logic r, logic rv, logic [31:0] rpc, logic ack,
                                     logic [31:0] rdata, logic ready);
    bit align_check;
`ifdef FETCH_ALIGN_CHECK_EN
    align_check = 1'b1;
`else
    align_check = 1'b0;
`endif
    if (r) begin
      m_pc = 32'h0; m_hold = 0; m_fault = 0; m_instr = 32'h0; m_ipc = 32'h0;
    end else if (rv) begin
      m_hold = 0;
      if (align_check && (rpc % 4 != 0)) m_fault = 1;
      else begin
        m_fault = 0;
        m_pc = rpc - (rpc % 4);
      end
    end else if (m_fault) begin
      // only a redirect or reset leaves the fault
    end else if (!m_hold) begin
      if (ack) begin
        m_instr = rdata; m_ipc = m_pc; m_hold = 1;
        m_pc = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
      end
    end else if (ready) begin
      m_hold = 0;
    end
  endfunction

  localparam logic [31:0] A0 = 32'h1111_0000;
  localparam logic [31:0] A1 = 32'h1111_0004;
  localparam logic [31:0] A2 = 32'h2002_0005;
  localparam logic [31:0] B0 = 32'hBBBB_0040;
  localparam logic [31:0] C0 = 32'hCCCC_FFFC;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;

    // Reset state while rst is held
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 1, JUNK, 1);
    check_outs("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("reset.instr", instr, 32'h0);
    chk("reset.instr_pc", instr_pc, 32'h0);

    //                rv rpc           ack rdata ready   req addr          valid instr ipc            mis
    vecs.push_back(mk(0, 0,            1, A0,   1,       1, 32'h0,         0, 0,  0,             0)); // first fetch at RESET_PC
    vecs.push_back(mk(0, 0,            1, A1,   1,       0, 0,             1, A0, 32'h0,         0));
    vecs.push_back(mk(0, 0,            1, A1,   1,       1, 32'h4,         0, 0,  0,             0));
    vecs.push_back(mk(0, 0,            0, JUNK, 1,       0, 0,             1, A1, 32'h4,         0));
    vecs.push_back(mk(0, 0,            0, JUNK, 1,       1, 32'h8,         0, 0,  0,             0)); // ack stall x3
    vecs.push_back(mk(0, 0,            0, JUNK, 1,       1, 32'h8,         0, 0,  0,             0));
    vecs.push_back(mk(0, 0,            0, JUNK, 1,       1, 32'h8,         0, 0,  0,             0));
    vecs.push_back(mk(0, 0,            1, A2,   0,       1, 32'h8,         0, 0,  0,             0));
    vecs.push_back(mk(0, 0,            1, JUNK, 0,       0, 0,             1, A2, 32'h8,         0)); // ready stall x4
    vecs.push_back(mk(0, 0,            1, JUNK, 0,       0, 0,             1, A2, 32'h8,         0));
    vecs.push_back(mk(0, 0,            1, JUNK, 0,       0, 0,             1, A2, 32'h8,         0));
    vecs.push_back(mk(0, 0,            1, JUNK, 0,       0, 0,             1, A2, 32'h8,         0));
    vecs.push_back(mk(0, 0,            0, JUNK, 1,       0, 0,             1, A2, 32'h8,         0));
    vecs.push_back(mk(1, 32'h40,       1, JUNK, 1,       1, 32'hC,         0, 0,  0,             0)); // redirect beats ack
    vecs.push_back(mk(0, 0,            1, B0,   0,       1, 32'h40,        0, 0,  0,             0));
    vecs.push_back(mk(0, 0,            0, JUNK, 0,       0, 0,             1, B0, 32'h40,        0));
    vecs.push_back(mk(1, 32'hFFFF_FFFC,0, JUNK, 0,       0, 0,             1, B0, 32'h40,        0)); // redirect from OUT
    vecs.push_back(mk(0, 0,            1, C0,   0,       1, 32'hFFFF_FFFC, 0, 0,  0,             0));
    vecs.push_back(mk(0, 0,            0, JUNK, 1,       0, 0,             1, C0, 32'hFFFF_FFFC, 0));
    vecs.push_back(mk(0, 0,            0, JUNK, 0,       1, 32'h0,         0, 0,  0,             0)); // pc wrapped
    vecs.push_back(mk(1, 32'h42,       0, JUNK, 0,       1, 32'h0,         0, 0,  0,             0));
`ifdef FETCH_ALIGN_CHECK_EN
    vecs.push_back(mk(0, 0,            1, JUNK, 1,       0, 0,             0, 0,  0,             1));
    vecs.push_back(mk(1, 32'h80,       1, JUNK, 1,       0, 0,             0, 0,  0,             1));
    vecs.push_back(mk(0, 0,            0, JUNK, 0,       1, 32'h80,        0, 0,  0,             0));
`else
    vecs.push_back(mk(0, 0,            0, JUNK, 0,       1, 32'h40,        0, 0,  0,             0));
    vecs.push_back(mk(1, 32'h80,       0, JUNK, 0,       1, 32'h40,        0, 0,  0,             0));
    vecs.push_back(mk(0, 0,            0, JUNK, 0,       1, 32'h80,        0, 0,  0,             0));
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].rv, vecs[i].rpc, vecs[i].ack, vecs[i].rdata, vecs[i].ready);
      check_outs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
                 vecs[i].e_instr, vecs[i].e_ipc, vecs[i].e_mis);
      $display("vec %0d rv=%b ack=%b ready=%b -> req=%b addr=%h valid=%b instr=%h pc=%h mis=%b",
               i, vecs[i].rv, vecs[i].ack, vecs[i].ready, imem_req, imem_addr,
               instr_valid, instr, instr_pc, misalign);
    end

    // Reset mid-operation discards the held instruction
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, A0, 0);
    check_outs("midrst.fetch", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(0, 0, 0, 0, JUNK, 0);
    check_outs("midrst.hold", 1'b0, 32'h0, 1'b1, A0, 32'h0, 1'b0);
    drive(1, 0, 0, 1, JUNK, 0);
    drive(1, 0, 0, 1, JUNK, 0);
    check_outs("midrst.inrst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("midrst.instr", instr, 32'h0);
    drive(0, 0, 0, 0, JUNK, 0);
    check_outs("midrst.release", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);

    // Randomized traffic against the model
    drive(1, 0, 0, 0, 0, 0);
    model_step(1, 0, 0, 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      logic r, rv, ack, ready;
      logic [31:0] rpc, rdata;
      r     = ($urandom_range(0, 99) < 2);
      rv    = ($urandom_range(0, 99) < 8);
      ack   = ($urandom_range(0, 99) < 60);
      ready = ($urandom_range(0, 99) < 60);
      rdata = $urandom;
      rpc   = $urandom;
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      if ($urandom_range(0, 9) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
      drive(r, rv, rpc, ack, rdata, ready);
      check_outs($sformatf("rnd%0d", n), !r && !m_fault && !m_hold, m_pc, m_hold,
                 m_instr, m_ipc, m_fault && !r);
      model_step(r, rv, rpc, ack, rdata, ready);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
